// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control path: opcodes, functs,
// ALU codes, datapath mux selects and the HI/LO sequencer state.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   localparam logic [1:0] PCSEL_PC4 = 2'b00;
   localparam logic [1:0] PCSEL_BR  = 2'b01;
   localparam logic [1:0] PCSEL_J   = 2'b10;
   localparam logic [1:0] PCSEL_JR  = 2'b11;

   localparam logic [1:0] M2R_ALU  = 2'b00;
   localparam logic [1:0] M2R_MEM  = 2'b01;
   localparam logic [1:0] M2R_PC4  = 2'b10;
   localparam logic [1:0] M2R_HILO = 2'b11;

   localparam logic [1:0] RDST_RT  = 2'b00;
   localparam logic [1:0] RDST_RD  = 2'b01;
   localparam logic [1:0] RDST_RA  = 2'b10;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_BUSY = 1'b1
   } seq_state_t;

endpackage

// File: rtl/md_sequencer.sv
// HI/LO occupancy tracker: a start strobe holds the unit busy for the
// mult or div latency, counted down to zero before returning to idle.
module md_sequencer
   import mips_ctrl_pkg::*;
#(
   parameter int MULT_LATENCY = 4,
   parameter int DIV_LATENCY  = 8,
   parameter int CNT_W        = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   input  logic i_op,
   output logic o_busy
);

   seq_state_t       r_state, w_state_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= SEQ_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Counter holds latency-1 so a latency of 1 gives a single busy cycle.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         SEQ_IDLE: begin
            if (i_start) begin
               w_state_next = SEQ_BUSY;
               w_cnt_next   = i_op ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MULT_LATENCY - 1);
            end
         end
         SEQ_BUSY: begin
            if (r_cnt == '0) w_state_next = SEQ_IDLE;
            else             w_cnt_next   = r_cnt - 1'b1;
         end
         default: w_state_next = SEQ_IDLE;
      endcase
   end

   assign o_busy = (r_state == SEQ_BUSY);

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage decode and branch resolution, plus the control fields carried
// through ID/EX, EX/MEM and MEM/WB, with HI/LO hazard stalling.
module pipelined_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W    = 3,
   parameter int MULT_LATENCY = 4,
   parameter int DIV_LATENCY  = 8,
   parameter int CNT_W        = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [5:0]           i_Op,
   input  logic [5:0]           i_funct,
   input  logic                 i_EqualD,
   input  logic                 i_FlushE,
   output logic                 o_PCSrcD,
   output logic [1:0]           o_PC_SelD,
   output logic                 o_BranchD,
   output logic                 o_JumpRD,
   output logic                 o_LoadD,
   output logic                 o_IllegalD,
   output logic                 o_MdStallD,
   output logic                 o_RegWriteE,
   output logic                 o_RegWriteM,
   output logic                 o_RegWriteW,
   output logic [1:0]           o_MemtoRegE,
   output logic [1:0]           o_MemtoRegW,
   output logic                 o_MemWriteE,
   output logic                 o_MemWriteM,
   output logic [ALUCTRL_W-1:0] o_ALUControlE,
   output logic                 o_ALUSrcE,
   output logic [1:0]           o_RegDstE,
   output logic                 o_LoadE,
   output logic                 o_MdStartE,
   output logic                 o_MdOpE,
   output logic                 o_MdSelHiE,
   output logic                 o_MdBusy
);

   logic       w_rw, w_mw, w_alusrc, w_load, w_md, w_mdop, w_hilo, w_selhi;
   logic       w_beq, w_bne, w_j, w_jr, w_illegal, w_taken, w_bubble;
   logic [1:0] w_m2r, w_regdst;
   logic [2:0] w_alu;

   always_comb begin
      w_rw = 1'b0;  w_mw = 1'b0;  w_alusrc = 1'b0; w_load = 1'b0;
      w_md = 1'b0;  w_mdop = 1'b0; w_hilo = 1'b0;  w_selhi = 1'b0;
      w_beq = 1'b0; w_bne = 1'b0; w_j = 1'b0;      w_jr = 1'b0;
      w_illegal = 1'b0;
      w_m2r = M2R_ALU; w_regdst = RDST_RT; w_alu = ALU_AND;
      case (i_Op)
         OP_RTYPE: begin
            case (i_funct)
               FN_ADD:  begin w_rw = 1'b1; w_regdst = RDST_RD; w_alu = ALU_ADD; end
               FN_SUB:  begin w_rw = 1'b1; w_regdst = RDST_RD; w_alu = ALU_SUB; end
               FN_AND:  begin w_rw = 1'b1; w_regdst = RDST_RD; w_alu = ALU_AND; end
               FN_OR:   begin w_rw = 1'b1; w_regdst = RDST_RD; w_alu = ALU_OR;  end
               FN_SLT:  begin w_rw = 1'b1; w_regdst = RDST_RD; w_alu = ALU_SLT; end
               FN_JR:   w_jr = 1'b1;
               FN_MULT: w_md = 1'b1;
               FN_DIV:  begin w_md = 1'b1; w_mdop = 1'b1; end
               FN_MFHI: begin
                  w_rw = 1'b1; w_regdst = RDST_RD; w_m2r = M2R_HILO;
                  w_hilo = 1'b1; w_selhi = 1'b1;
               end
               FN_MFLO: begin
                  w_rw = 1'b1; w_regdst = RDST_RD; w_m2r = M2R_HILO; w_hilo = 1'b1;
               end
               default: w_illegal = 1'b1;
            endcase
         end
         OP_LW:   begin w_rw = 1'b1; w_alusrc = 1'b1; w_m2r = M2R_MEM; w_alu = ALU_ADD; w_load = 1'b1; end
         OP_SW:   begin w_mw = 1'b1; w_alusrc = 1'b1; w_alu = ALU_ADD; end
         OP_BEQ:  begin w_beq = 1'b1; w_alu = ALU_SUB; end
         OP_BNE:  begin w_bne = 1'b1; w_alu = ALU_SUB; end
         OP_ADDI: begin w_rw = 1'b1; w_alusrc = 1'b1; w_alu = ALU_ADD; end
         OP_J:    w_j = 1'b1;
         OP_JAL:  begin w_j = 1'b1; w_rw = 1'b1; w_regdst = RDST_RA; w_m2r = M2R_PC4; end
         default: w_illegal = 1'b1;
      endcase
   end

   // A HI/LO user may not leave ID while the unit is starting or occupied.
   assign o_MdStallD = (w_md | w_hilo) & (o_MdBusy | o_MdStartE);
   assign w_taken    = (w_beq & i_EqualD) | (w_bne & ~i_EqualD);
   assign o_PCSrcD   = ~o_MdStallD & (w_j | w_jr | w_taken);
   assign o_PC_SelD  = ~o_PCSrcD ? PCSEL_PC4 :
                       w_jr      ? PCSEL_JR  :
                       w_j       ? PCSEL_J   : PCSEL_BR;
   assign o_BranchD  = w_beq | w_bne;
   assign o_JumpRD   = w_jr;
   assign o_LoadD    = w_load;
   assign o_IllegalD = w_illegal;
   assign w_bubble   = i_FlushE | o_MdStallD | w_illegal;

   logic                 r_RegWriteE, r_MemWriteE, r_ALUSrcE, r_LoadE;
   logic                 r_MdStartE, r_MdOpE, r_MdSelHiE;
   logic [1:0]           r_MemtoRegE, r_RegDstE;
   logic [ALUCTRL_W-1:0] r_ALUControlE;
   logic                 r_RegWriteM, r_MemWriteM, r_RegWriteW;
   logic [1:0]           r_MemtoRegM, r_MemtoRegW;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_RegWriteE <= 1'b0; r_MemWriteE <= 1'b0; r_ALUSrcE <= 1'b0; r_LoadE <= 1'b0;
         r_MdStartE  <= 1'b0; r_MdOpE     <= 1'b0; r_MdSelHiE <= 1'b0;
         r_MemtoRegE <= '0;   r_RegDstE   <= '0;   r_ALUControlE <= '0;
         r_RegWriteM <= 1'b0; r_MemWriteM <= 1'b0; r_MemtoRegM <= '0;
         r_RegWriteW <= 1'b0; r_MemtoRegW <= '0;
      end else begin
         r_RegWriteE   <= w_rw     & ~w_bubble;
         r_MemWriteE   <= w_mw     & ~w_bubble;
         r_ALUSrcE     <= w_alusrc & ~w_bubble;
         r_LoadE       <= w_load   & ~w_bubble;
         r_MdStartE    <= w_md     & ~w_bubble;
         r_MdOpE       <= w_mdop   & ~w_bubble;
         r_MdSelHiE    <= w_selhi  & ~w_bubble;
         r_MemtoRegE   <= w_bubble ? M2R_ALU : w_m2r;
         r_RegDstE     <= w_bubble ? RDST_RT : w_regdst;
         r_ALUControlE <= w_bubble ? '0 : ALUCTRL_W'(w_alu);
         r_RegWriteM   <= r_RegWriteE;
         r_MemWriteM   <= r_MemWriteE;
         r_MemtoRegM   <= r_MemtoRegE;
         r_RegWriteW   <= r_RegWriteM;
         r_MemtoRegW   <= r_MemtoRegM;
      end
   end

   assign o_RegWriteE   = r_RegWriteE;
   assign o_MemWriteE   = r_MemWriteE;
   assign o_ALUSrcE     = r_ALUSrcE;
   assign o_LoadE       = r_LoadE;
   assign o_MdStartE    = r_MdStartE;
   assign o_MdOpE       = r_MdOpE;
   assign o_MdSelHiE    = r_MdSelHiE;
   assign o_MemtoRegE   = r_MemtoRegE;
   assign o_RegDstE     = r_RegDstE;
   assign o_ALUControlE = r_ALUControlE;
   assign o_RegWriteM   = r_RegWriteM;
   assign o_MemWriteM   = r_MemWriteM;
   assign o_RegWriteW   = r_RegWriteW;
   assign o_MemtoRegW   = r_MemtoRegW;

   md_sequencer #(
      .MULT_LATENCY (MULT_LATENCY),
      .DIV_LATENCY  (DIV_LATENCY),
      .CNT_W        (CNT_W)
   ) u_md_sequencer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (r_MdStartE),
      .i_op    (r_MdOpE),
      .o_busy  (o_MdBusy)
   );

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed and random checks of pipelined_control_unit against an
// instruction-table reference model with a cycle-count HI/LO occupancy model.
module tb_pipelined_control_unit;

   localparam int MULT_LAT = 4;
   localparam int DIV_LAT  = 8;

   logic       clk, i_rst, i_EqualD, i_FlushE;
   logic [5:0] i_Op, i_funct;
   logic       o_PCSrcD, o_BranchD, o_JumpRD, o_LoadD, o_IllegalD, o_MdStallD;
   logic [1:0] o_PC_SelD, o_MemtoRegE, o_MemtoRegW, o_RegDstE;
   logic       o_RegWriteE, o_RegWriteM, o_RegWriteW, o_MemWriteE, o_MemWriteM;
   logic [2:0] o_ALUControlE;
   logic       o_ALUSrcE, o_LoadE, o_MdStartE, o_MdOpE, o_MdSelHiE, o_MdBusy;

   pipelined_control_unit #(
      .ALUCTRL_W(3), .MULT_LATENCY(MULT_LAT), .DIV_LATENCY(DIV_LAT), .CNT_W(4)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_Op(i_Op), .i_funct(i_funct),
      .i_EqualD(i_EqualD), .i_FlushE(i_FlushE),
      .o_PCSrcD(o_PCSrcD), .o_PC_SelD(o_PC_SelD), .o_BranchD(o_BranchD),
      .o_JumpRD(o_JumpRD), .o_LoadD(o_LoadD), .o_IllegalD(o_IllegalD),
      .o_MdStallD(o_MdStallD), .o_RegWriteE(o_RegWriteE), .o_RegWriteM(o_RegWriteM),
      .o_RegWriteW(o_RegWriteW), .o_MemtoRegE(o_MemtoRegE), .o_MemtoRegW(o_MemtoRegW),
      .o_MemWriteE(o_MemWriteE), .o_MemWriteM(o_MemWriteM), .o_ALUControlE(o_ALUControlE),
      .o_ALUSrcE(o_ALUSrcE), .o_RegDstE(o_RegDstE), .o_LoadE(o_LoadE),
      .o_MdStartE(o_MdStartE), .o_MdOpE(o_MdOpE), .o_MdSelHiE(o_MdSelHiE),
      .o_MdBusy(o_MdBusy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row per legal instruction: what it asks of the datapath.
   typedef struct packed {
      logic [5:0] op; logic [5:0] fn; logic rtype;
      logic rw; logic [1:0] m2r; logic mw; logic [2:0] alu; logic asrc;
      logic [1:0] rdst; logic ld; logic md; logic mdop; logic hilo; logic selhi;
      logic [1:0] br;    // 1 beq, 2 bne
      logic [1:0] jsel;  // unconditional redirect select, 0 if none
   } instr_t;

   typedef struct packed {
      logic rw; logic [1:0] m2r; logic mw; logic [2:0] alu; logic asrc;
      logic [1:0] rdst; logic ld; logic md; logic mdop; logic selhi;
   } stage_t;

   localparam int NI = 17;
   localparam int I_ADD = 0, I_JR = 5, I_MULT = 6, I_DIV = 7, I_MFHI = 8,
                  I_LW = 10, I_SW = 11, I_BEQ = 12, I_BNE = 13, I_JAL = 16;

   instr_t tbl [NI];
   stage_t mE, mM, mW;
   int     busy_left;
   int     checks = 0, failures = 0;
   logic   obs_pcsrc, obs_stall, obs_start, obs_busy, obs_illegal;
   logic [1:0] obs_pcsel;

   function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn, input logic rt,
         input logic rw, input logic [1:0] m2r, input logic mw, input logic [2:0] alu,
         input logic asrc, input logic [1:0] rdst, input logic ld, input logic md,
         input logic mdop, input logic hilo, input logic selhi,
         input logic [1:0] br, input logic [1:0] jsel);
      instr_t t;
      t.op = op; t.fn = fn; t.rtype = rt; t.rw = rw; t.m2r = m2r; t.mw = mw;
      t.alu = alu; t.asrc = asrc; t.rdst = rdst; t.ld = ld; t.md = md; t.mdop = mdop;
      t.hilo = hilo; t.selhi = selhi; t.br = br; t.jsel = jsel;
      return t;
   endfunction

   function automatic int find(input logic [5:0] op, input logic [5:0] fn);
      for (int k = 0; k < NI; k++)
         if (tbl[k].op == op && (!tbl[k].rtype || tbl[k].fn == fn)) return k;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_cycle(input logic [5:0] op, input logic [5:0] fn,
                           input logic eq, input logic flush);
      int idx; instr_t d; logic illegal, busy, start, stall, taken; logic [1:0] pcsel;
      stage_t nxt;
      @(negedge clk);
      i_Op = op; i_funct = fn; i_EqualD = eq; i_FlushE = flush;
      #2;
      idx = find(op, fn);
      illegal = (idx < 0);
      d = illegal ? '0 : tbl[idx];
      busy  = (busy_left > 0);
      start = mE.md;
      stall = (d.md | d.hilo) & (busy | start);
      taken = ~stall & ((d.jsel != 2'b00) | (d.br == 2'd1 & eq) | (d.br == 2'd2 & ~eq));
      pcsel = !taken ? 2'b00 : (d.jsel != 2'b00) ? d.jsel : 2'b01;
      $display("cyc t=%0t op=%02h fn=%02h eq=%0b flush=%0b stall=%0b busy=%0b start=%0b",
               $time, op, fn, eq, flush, o_MdStallD, o_MdBusy, o_MdStartE);
      chk("PCSrcD", o_PCSrcD, taken);          chk("PC_SelD", o_PC_SelD, pcsel);
      chk("BranchD", o_BranchD, d.br != 0);    chk("JumpRD", o_JumpRD, d.jsel == 2'b11);
      chk("LoadD", o_LoadD, d.ld);             chk("IllegalD", o_IllegalD, illegal);
      chk("MdStallD", o_MdStallD, stall);      chk("MdBusy", o_MdBusy, busy);
      chk("RegWriteE", o_RegWriteE, mE.rw);    chk("MemtoRegE", o_MemtoRegE, mE.m2r);
      chk("MemWriteE", o_MemWriteE, mE.mw);    chk("ALUControlE", o_ALUControlE, mE.alu);
      chk("ALUSrcE", o_ALUSrcE, mE.asrc);      chk("RegDstE", o_RegDstE, mE.rdst);
      chk("LoadE", o_LoadE, mE.ld);            chk("MdStartE", o_MdStartE, mE.md);
      chk("MdOpE", o_MdOpE, mE.mdop);          chk("MdSelHiE", o_MdSelHiE, mE.selhi);
      chk("RegWriteM", o_RegWriteM, mM.rw);    chk("MemWriteM", o_MemWriteM, mM.mw);
      chk("RegWriteW", o_RegWriteW, mW.rw);    chk("MemtoRegW", o_MemtoRegW, mW.m2r);
      obs_pcsrc = o_PCSrcD; obs_pcsel = o_PC_SelD; obs_stall = o_MdStallD;
      obs_start = o_MdStartE; obs_busy = o_MdBusy; obs_illegal = o_IllegalD;
      // Occupancy model: a start makes the unit busy for exactly LAT following cycles.
      if (start) busy_left = mE.mdop ? DIV_LAT : MULT_LAT;
      else if (busy_left > 0) busy_left--;
      nxt.rw = d.rw; nxt.m2r = d.m2r; nxt.mw = d.mw; nxt.alu = d.alu; nxt.asrc = d.asrc;
      nxt.rdst = d.rdst; nxt.ld = d.ld; nxt.md = d.md; nxt.mdop = d.mdop; nxt.selhi = d.selhi;
      mW = mM; mM = mE;
      mE = (flush | stall | illegal) ? '0 : nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int idx, input logic eq, input logic flush);
      do_cycle(tbl[idx].op, tbl[idx].fn, eq, flush);
   endtask

   task automatic reset_mid();
      @(negedge clk);
      i_Op = tbl[I_MFHI].op; i_funct = tbl[I_MFHI].fn; i_FlushE = 1'b0;
      #2 i_rst = 1'b1;
      #1;
      $display("rst t=%0t asserted mid-cycle", $time);
      chk("rst_MdBusy", o_MdBusy, 0);       chk("rst_MdStallD", o_MdStallD, 0);
      chk("rst_RegWriteE", o_RegWriteE, 0); chk("rst_MdStartE", o_MdStartE, 0);
      chk("rst_RegWriteM", o_RegWriteM, 0); chk("rst_RegWriteW", o_RegWriteW, 0);
      chk("rst_MemtoRegE", o_MemtoRegE, 0); chk("rst_MemWriteM", o_MemWriteM, 0);
      mE = '0; mM = '0; mW = '0; busy_left = 0;
      @(posedge clk);
      #1 i_rst = 1'b0;
   endtask

   initial begin
      int n, nstall, nbusy, nstart, r;
      logic done;
      tbl[0]  = mk(6'h00, 6'h20, 1, 1, 2'b00, 0, 3'b010, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00);
      tbl[1]  = mk(6'h00, 6'h22, 1, 1, 2'b00, 0, 3'b110, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00);
      tbl[2]  = mk(6'h00, 6'h24, 1, 1, 2'b00, 0, 3'b000, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00);
      tbl[3]  = mk(6'h00, 6'h25, 1, 1, 2'b00, 0, 3'b001, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00);
      tbl[4]  = mk(6'h00, 6'h2A, 1, 1, 2'b00, 0, 3'b111, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00);
      tbl[5]  = mk(6'h00, 6'h08, 1, 0, 2'b00, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11);
      tbl[6]  = mk(6'h00, 6'h18, 1, 0, 2'b00, 0, 3'b000, 0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00);
      tbl[7]  = mk(6'h00, 6'h1A, 1, 0, 2'b00, 0, 3'b000, 0, 2'b00, 0, 1, 1, 0, 0, 0, 2'b00);
      tbl[8]  = mk(6'h00, 6'h10, 1, 1, 2'b11, 0, 3'b000, 0, 2'b01, 0, 0, 0, 1, 1, 0, 2'b00);
      tbl[9]  = mk(6'h00, 6'h12, 1, 1, 2'b11, 0, 3'b000, 0, 2'b01, 0, 0, 0, 1, 0, 0, 2'b00);
      tbl[10] = mk(6'h23, 6'h00, 0, 1, 2'b01, 0, 3'b010, 1, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00);
      tbl[11] = mk(6'h2B, 6'h00, 0, 0, 2'b00, 1, 3'b010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
      tbl[12] = mk(6'h04, 6'h00, 0, 0, 2'b00, 0, 3'b110, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00);
      tbl[13] = mk(6'h05, 6'h00, 0, 0, 2'b00, 0, 3'b110, 0, 2'b00, 0, 0, 0, 0, 0, 2, 2'b00);
      tbl[14] = mk(6'h08, 6'h00, 0, 1, 2'b00, 0, 3'b010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
      tbl[15] = mk(6'h02, 6'h00, 0, 0, 2'b00, 0, 3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10);
      tbl[16] = mk(6'h03, 6'h00, 0, 1, 2'b10, 0, 3'b000, 0, 2'b10, 0, 0, 0, 0, 0, 0, 2'b10);
      mE = '0; mM = '0; mW = '0; busy_left = 0;

      i_rst = 1'b1; i_Op = 6'h00; i_funct = 6'h20; i_EqualD = 1'b0; i_FlushE = 1'b0;
      repeat (2) @(posedge clk);
      #1 i_rst = 1'b0;
      chk("init_RegWriteE", o_RegWriteE, 0); chk("init_MdBusy", o_MdBusy, 0);
      chk("init_MemtoRegW", o_MemtoRegW, 0); chk("init_MdStartE", o_MdStartE, 0);

      issue(I_ADD, 0, 0);
      chk("add_RegWriteE", o_RegWriteE, 1); chk("add_RegDstE", o_RegDstE, 2'b01);
      chk("add_ALUControlE", o_ALUControlE, 3'b010);
      issue(I_BNE, 0, 0);
      chk("bne_PCSrcD", obs_pcsrc, 1); chk("bne_PC_SelD", obs_pcsel, 2'b01);
      chk("add_RegWriteM", o_RegWriteM, 1);
      issue(I_BEQ, 0, 0);
      chk("beq_PCSrcD", obs_pcsrc, 0); chk("beq_PC_SelD", obs_pcsel, 2'b00);
      chk("add_RegWriteW", o_RegWriteW, 1);
      issue(I_JR, 0, 0);
      chk("jr_PC_SelD", obs_pcsel, 2'b11);
      issue(I_JAL, 0, 0);
      chk("jal_RegDstE", o_RegDstE, 2'b10); chk("jal_MemtoRegE", o_MemtoRegE, 2'b10);

      issue(I_LW, 0, 0);
      issue(I_SW, 0, 0);
      reset_mid();
      issue(I_ADD, 0, 0);

      // mult followed by mfhi: count strobes, busy and stalled cycles.
      issue(I_MULT, 0, 0);
      nstall = 0; nbusy = 0; nstart = 0; done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         issue(I_MFHI, 0, 0);
         nstart += int'(obs_start); nbusy += int'(obs_busy);
         if (obs_stall) nstall++; else done = 1'b1;
      end
      chk("mult_wait_bound", 8'(done), 1);
      chk("mult_start_pulses", 8'(nstart), 1);
      chk("mult_busy_cycles", 8'(nbusy), MULT_LAT);
      chk("mult_stall_cycles", 8'(nstall), MULT_LAT + 1);
      chk("mfhi_MemtoRegE", o_MemtoRegE, 2'b11); chk("mfhi_MdSelHiE", o_MdSelHiE, 1);

      // div, then reset during its third busy cycle.
      issue(I_DIV, 0, 0);
      issue(I_ADD, 0, 0);
      issue(I_ADD, 0, 0);
      issue(I_ADD, 0, 0);
      chk("div_busy_before_rst", o_MdBusy, 1);
      reset_mid();
      issue(I_MFHI, 0, 0);
      chk("div_rst_no_stall", obs_stall, 0); chk("div_rst_not_busy", obs_busy, 0);

      issue(I_MULT, 0, 1);
      issue(I_ADD, 0, 0);
      chk("flush_no_start", obs_start, 0); chk("flush_not_busy", obs_busy, 0);
      do_cycle(6'h3F, 6'h20, 0, 0);
      chk("ill_IllegalD", obs_illegal, 1); chk("ill_RegWriteE", o_RegWriteE, 0);
      chk("ill_ALUControlE", o_ALUControlE, 0);

      for (int k = 0; k < 400; k++) begin
         r = int'($urandom_range(0, 63));
         if (r == 0) reset_mid();
         else begin
            n = int'($urandom_range(0, NI + 1));
            if (n >= NI) do_cycle((n == NI) ? 6'h3F : 6'h00, 6'h3F, 1'($urandom), 1'($urandom_range(0, 7) == 0));
            else if (tbl[n].rtype) issue(n, 1'($urandom), 1'($urandom_range(0, 7) == 0));
            else do_cycle(tbl[n].op, 6'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
